// File: rtl/pc_sequencer.sv
// Program-counter stage for the pipelined fetch path. It selects the next PC from branch,
// jump and sequential sources, and it holds one redirect that arrives while fetch is stalled.
module pc_sequencer #(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] INC        = WIDTH'(4),
    parameter logic [WIDTH-1:0] RESET_PC   = '0,
    parameter int               ALIGN_BITS = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_seq,
    output logic             redirect_pending,
    output logic             misaligned
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic             pend_valid_q, pend_valid_d;
    logic [WIDTH-1:0] pend_target_q, pend_target_d;

    assign pc_seq = pc_q + INC;

    always_comb begin
        pc_d          = pc_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        if (!stall) begin
            // Branch (EX) is older than a buffered redirect, which is older than a jump (ID).
            if (branch_taken)      pc_d = branch_target;
            else if (pend_valid_q) pc_d = pend_target_q;
            else if (jump)         pc_d = jump_target;
            else                   pc_d = pc_seq;
            pend_valid_d = 1'b0;
        end else if (branch_taken) begin
            pend_valid_d  = 1'b1;
            pend_target_d = branch_target;
        end else if (jump && !pend_valid_q) begin
            pend_valid_d  = 1'b1;
            pend_target_d = jump_target;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
        end else begin
            pc_q          <= pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

    assign pc               = pc_q;
    assign redirect_pending = pend_valid_q;

    generate
        if (ALIGN_BITS > 0) begin : g_align
            assign misaligned = |pc_q[ALIGN_BITS-1:0];
        end else begin : g_no_align
            assign misaligned = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer. A directed vector table is followed by a random phase,
// and the random phase is compared with a rule-level model. It covers a default instance
// and an instance with alternate parameters.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, stall, branch_taken, jump;
    logic [31:0] branch_target, jump_target;
    logic [31:0] pc, pc_seq, a_pc, a_pc_seq;
    logic        redirect_pending, misaligned, a_pend, a_mis;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    pc_sequencer u_dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .pc(pc), .pc_seq(pc_seq),
        .redirect_pending(redirect_pending), .misaligned(misaligned)
    );

    pc_sequencer #(.WIDTH(32), .INC(32'd5), .RESET_PC(32'hFFFF_FFFF), .ALIGN_BITS(3)) u_alt (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .pc(a_pc), .pc_seq(a_pc_seq),
        .redirect_pending(a_pend), .misaligned(a_mis)
    );

    typedef struct {
        logic [31:0] pc;
        logic        pv;
        logic [31:0] pt;
    } mstate_t;

    mstate_t m_def, m_alt;

    // Apply one clock edge to the model using the redirect rules, written as plain decisions.
    function automatic mstate_t mstep(input mstate_t s, input logic rst, input logic st,
                                      input logic br, input logic [31:0] bt,
                                      input logic j, input logic [31:0] jt,
                                      input logic [31:0] rpc, input logic [31:0] inc);
        mstate_t n = s;
        if (!rst) begin
            n.pc = rpc; n.pv = 1'b0; n.pt = 32'd0;
        end else if (!st) begin
            n.pc = br ? bt : (s.pv ? s.pt : (j ? jt : s.pc + inc));
            n.pv = 1'b0;
        end else if (br) begin
            n.pv = 1'b1; n.pt = bt;
        end else if (j && !s.pv) begin
            n.pv = 1'b1; n.pt = jt;
        end
        return n;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic step(input logic r, input logic st, input logic br, input logic [31:0] bt,
                        input logic j, input logic [31:0] jt);
        rst_n = r; stall = st; branch_taken = br; branch_target = bt;
        jump = j; jump_target = jt;
        @(posedge clk);
        m_def = mstep(m_def, r, st, br, bt, j, jt, 32'h0, 32'd4);
        m_alt = mstep(m_alt, r, st, br, bt, j, jt, 32'hFFFF_FFFF, 32'd5);
        @(negedge clk);
    endtask

    typedef struct {
        logic        rst_n, stall, br;
        logic [31:0] bt;
        logic        j;
        logic [31:0] jt;
        logic [31:0] e_pc;
        logic        e_pend, e_mis;
    } vec_t;

    vec_t tbl[$];

    initial begin
        m_def = '{32'h0, 1'b0, 32'h0};
        m_alt = '{32'hFFFF_FFFF, 1'b0, 32'h0};

        // Hold reset for two edges, then release it.
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        check("rst_pc", pc, 32'h0);
        check("rst_seq", pc_seq, 32'h4);
        check("rst_pend", {31'd0, redirect_pending}, 32'd0);
        check("rst_mis", {31'd0, misaligned}, 32'd0);
        check("alt_rst_pc", a_pc, 32'hFFFF_FFFF);
        check("alt_rst_seq", a_pc_seq, 32'h0000_0004);
        check("alt_rst_mis", {31'd0, a_mis}, 32'd1);
        check("alt_rst_pend", {31'd0, a_pend}, 32'd0);
        step(1, 0, 0, 0, 0, 0);
        check("first_inc", pc, 32'h4);
        check("alt_wrap_pc", a_pc, 32'h0000_0004);
        check("alt_wrap_mis", {31'd0, a_mis}, 32'd1);

        // Each entry: rst_n, stall, br, bt, j, jt -> expected pc, pending, misaligned.
        tbl = '{
            '{1,0,0,0,0,0, 32'h8, 0,0},
            '{1,0,0,0,0,0, 32'hC, 0,0},
            '{1,0,0,0,1,32'h100, 32'h100, 0,0},
            '{1,0,1,32'h400,1,32'h800, 32'h400, 0,0},
            '{1,0,0,0,1,32'h800, 32'h800, 0,0},
            '{1,0,0,0,1,32'h200, 32'h200, 0,0},
            '{1,1,0,0,1,32'h300, 32'h200, 1,0},
            '{1,1,1,32'h500,0,0, 32'h200, 1,0},
            '{1,1,0,0,1,32'h600, 32'h200, 1,0},
            '{1,0,0,0,0,0, 32'h500, 0,0},
            '{1,0,0,0,0,0, 32'h504, 0,0},
            '{1,1,0,0,1,32'h700, 32'h504, 1,0},
            '{0,1,0,0,0,0, 32'h0, 0,0},
            '{1,0,0,0,0,0, 32'h4, 0,0},
            '{1,0,0,0,0,0, 32'h8, 0,0},
            '{1,0,1,32'h102,0,0, 32'h102, 0,1},
            '{1,0,0,0,1,32'h108, 32'h108, 0,0},
            '{1,1,0,0,1,32'h40, 32'h108, 1,0},
            '{1,0,1,32'h80,0,0, 32'h80, 0,0},
            '{1,0,0,0,0,0, 32'h84, 0,0},
            '{1,1,0,0,1,32'h30, 32'h84, 1,0},
            '{1,0,0,0,1,32'h90, 32'h30, 0,0},
            '{1,0,0,0,0,0, 32'h34, 0,0},
            '{1,1,0,0,0,0, 32'h34, 0,0},
            '{1,0,0,0,1,32'hFFFF_FFFC, 32'hFFFF_FFFC, 0,0},
            '{1,0,0,0,0,0, 32'h0, 0,0}
        };
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst_n, tbl[i].stall, tbl[i].br, tbl[i].bt, tbl[i].j, tbl[i].jt);
            check($sformatf("vec%0d_pc", i), pc, tbl[i].e_pc);
            check($sformatf("vec%0d_seq", i), pc_seq, tbl[i].e_pc + 32'd4);
            check($sformatf("vec%0d_pend", i), {31'd0, redirect_pending}, {31'd0, tbl[i].e_pend});
            check($sformatf("vec%0d_mis", i), {31'd0, misaligned}, {31'd0, tbl[i].e_mis});
        end

        // Random traffic on both instances, compared with the model.
        for (int c = 0; c < 400; c++) begin
            logic        r, st, br, j;
            logic [31:0] bt, jt;
            r  = ($urandom_range(0, 31) != 0);
            st = ($urandom_range(0, 2) == 0);
            br = ($urandom_range(0, 5) == 0);
            j  = ($urandom_range(0, 4) == 0);
            bt = $urandom;
            jt = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                bt = bt & ~32'h3;
                jt = jt & ~32'h3;
            end
            if ($urandom_range(0, 15) == 0) bt = 32'hFFFF_FFF8 | ($urandom & 32'h7);
            step(r, st, br, bt, j, jt);
            check("rnd_pc", pc, m_def.pc);
            check("rnd_seq", pc_seq, m_def.pc + 32'd4);
            check("rnd_pend", {31'd0, redirect_pending}, {31'd0, m_def.pv});
            check("rnd_mis", {31'd0, misaligned}, {31'd0, m_def.pc[1:0] != 2'b00});
            check("rnd_alt_pc", a_pc, m_alt.pc);
            check("rnd_alt_seq", a_pc_seq, m_alt.pc + 32'd5);
            check("rnd_alt_pend", {31'd0, a_pend}, {31'd0, m_alt.pv});
            check("rnd_alt_mis", {31'd0, a_mis}, {31'd0, m_alt.pc[2:0] != 3'b000});
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
